// File: rtl/pcss_step_sched.sv
// Timestep scheduler for the host->chip send stream: forwards config words when idle,
// and in run mode emits each timestep's spikes, a closing TIK word and an idle window.
module pcss_step_sched #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned GAP_EXTRA  = 8,
  parameter int unsigned STEP_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] cfg_tdata,
  input  logic                  cfg_tvalid,
  output logic                  cfg_tready,
  input  logic [DATA_WIDTH-1:0] spk_tdata,
  input  logic                  spk_tvalid,
  input  logic                  spk_tlast,
  output logic                  spk_tready,
  output logic [DATA_WIDTH-1:0] out_tdata,
  output logic                  out_tvalid,
  input  logic                  out_tready,
  input  logic                  run_start,
  input  logic [STEP_W-1:0]     run_steps,
  input  logic [31:0]           tik_len,
  input  logic                  abort,
  output logic                  running,
  output logic [STEP_W-1:0]     step_cnt,
  output logic                  done,
  output logic [7:0]            drop_cnt
);

  localparam int unsigned GAP_W     = 33;
  localparam int unsigned TIK_LEN_W = 32;
  localparam int unsigned DROP_W    = 8;
  localparam logic [2:0]  TIK_TYPE  = 3'b011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPIKE,
    S_TIK,
    S_GAP,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic                  active_q;
  logic [DATA_WIDTH-1:0] out_tdata_q, out_tdata_d;
  logic                  out_tvalid_q, out_tvalid_d;
  logic                  running_q, running_d;
  logic [STEP_W-1:0]     step_cnt_q, step_cnt_d;
  logic [STEP_W-1:0]     steps_q, steps_d;
  logic [TIK_LEN_W-1:0]  tik_len_q, tik_len_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic                  aborted_q, aborted_d;
  logic                  done_q, done_d;
  logic [DROP_W-1:0]     drop_cnt_q, drop_cnt_d;
  logic                  buf_free;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      active_q     <= 1'b0;
      out_tdata_q  <= '0;
      out_tvalid_q <= 1'b0;
      running_q    <= 1'b0;
      step_cnt_q   <= '0;
      steps_q      <= '0;
      tik_len_q    <= '0;
      gap_cnt_q    <= '0;
      aborted_q    <= 1'b0;
      done_q       <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      active_q     <= 1'b1;
      out_tdata_q  <= out_tdata_d;
      out_tvalid_q <= out_tvalid_d;
      running_q    <= running_d;
      step_cnt_q   <= step_cnt_d;
      steps_q      <= steps_d;
      tik_len_q    <= tik_len_d;
      gap_cnt_q    <= gap_cnt_d;
      aborted_q    <= aborted_d;
      done_q       <= done_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Next-state, output buffer and handshake logic
  always_comb begin
    state_d      = state_q;
    out_tdata_d  = out_tdata_q;
    out_tvalid_d = out_tvalid_q && !out_tready;
    running_d    = running_q;
    step_cnt_d   = step_cnt_q;
    steps_d      = steps_q;
    tik_len_d    = tik_len_q;
    gap_cnt_d    = gap_cnt_q;
    aborted_d    = aborted_q;
    done_d       = 1'b0;
    drop_cnt_d   = drop_cnt_q;
    cfg_tready   = 1'b0;
    spk_tready   = 1'b0;
    buf_free     = active_q && (!out_tvalid_q || out_tready);

    case (state_q)
      S_IDLE: begin
        cfg_tready = buf_free;
        if (cfg_tvalid && buf_free) begin
          out_tvalid_d = 1'b1;
          out_tdata_d  = cfg_tdata;
        end
        if (run_start) begin
          step_cnt_d = '0;
          if (run_steps != '0) begin
            state_d   = S_SPIKE;
            steps_d   = run_steps;
            tik_len_d = tik_len;
            running_d = 1'b1;
            aborted_d = 1'b0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_SPIKE: begin
        // Every word is a single beat, so any cycle is a safe abort point
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_TIK;
        end else begin
          spk_tready = buf_free;
          if (spk_tvalid && buf_free) begin
            if (spk_tdata[58:56] == TIK_TYPE) begin
              if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_W'(1);
            end else begin
              out_tvalid_d = 1'b1;
              out_tdata_d  = spk_tdata;
            end
            if (spk_tlast) state_d = S_TIK;
          end
        end
      end
      S_TIK: begin
        if (abort) aborted_d = 1'b1;
        if (buf_free) begin
          out_tvalid_d = 1'b1;
          out_tdata_d  = DATA_WIDTH'({5'b0, TIK_TYPE, 24'b0, tik_len_q});
          gap_cnt_d    = GAP_W'(tik_len_q) + GAP_W'(GAP_EXTRA);
          state_d      = S_GAP;
        end
      end
      S_GAP: begin
        if (abort) aborted_d = 1'b1;
        // The window only starts once the TIK word has left the buffer
        if (!out_tvalid_q) begin
          if (gap_cnt_q != '0) begin
            gap_cnt_d = gap_cnt_q - GAP_W'(1);
          end else begin
            step_cnt_d = step_cnt_q + STEP_W'(1);
            if (aborted_q || abort || (step_cnt_d == steps_q)) begin
              state_d   = S_DONE;
              running_d = 1'b0;
              done_d    = 1'b1;
            end else begin
              state_d = S_SPIKE;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign out_tdata  = out_tdata_q;
  assign out_tvalid = out_tvalid_q;
  assign running    = running_q;
  assign step_cnt   = step_cnt_q;
  assign done       = done_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_pcss_step_sched.sv
// Self-checking bench for pcss_step_sched: random spike traffic per timestep is
// compared against an expected word list built from the scheduling rules.
module tb_pcss_step_sched;

  localparam int unsigned DW        = 64;
  localparam int unsigned GAP_EXTRA = 8;
  localparam int unsigned STEP_W    = 16;
  localparam logic [2:0]  TIK_T     = 3'b011;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DW-1:0]     cfg_tdata;
  logic              cfg_tvalid;
  logic              cfg_tready;
  logic [DW-1:0]     spk_tdata;
  logic              spk_tvalid;
  logic              spk_tlast;
  logic              spk_tready;
  logic [DW-1:0]     out_tdata;
  logic              out_tvalid;
  logic              out_tready;
  logic              run_start;
  logic [STEP_W-1:0] run_steps;
  logic [31:0]       tik_len;
  logic              abort;
  logic              running;
  logic [STEP_W-1:0] step_cnt;
  logic              done;
  logic [7:0]        drop_cnt;

  always #5 clk = ~clk;

  pcss_step_sched #(.DATA_WIDTH(DW), .GAP_EXTRA(GAP_EXTRA), .STEP_W(STEP_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_tdata(cfg_tdata), .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready),
    .spk_tdata(spk_tdata), .spk_tvalid(spk_tvalid), .spk_tlast(spk_tlast), .spk_tready(spk_tready),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .run_start(run_start), .run_steps(run_steps), .tik_len(tik_len), .abort(abort),
    .running(running), .step_cnt(step_cnt), .done(done), .drop_cnt(drop_cnt)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          bp_mode = 0;
  logic [63:0] mon_q[$];
  int          mon_cyc[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  bit          stall_pend = 1'b0;
  logic [63:0] stall_data = '0;
  int          drop_exp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Sink backpressure: 0 = always ready, 1 = toggle, 2 = random
  initial begin
    out_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (bp_mode)
        1:       out_tready = ~out_tready;
        2:       out_tready = 1'($urandom_range(0, 1));
        default: out_tready = 1'b1;
      endcase
    end
  end

  // Output monitor: captures handshaked words, checks hold-while-stalled, counts done
  initial begin
    forever begin
      @(negedge clk);
      if (stall_pend && rst_n) begin
        check("hold_valid", 64'(out_tvalid), 64'd1);
        check("hold_data", out_tdata, stall_data);
      end
      stall_pend = rst_n && out_tvalid && !out_tready;
      stall_data = out_tdata;
      if (out_tvalid && out_tready) begin
        mon_q.push_back(out_tdata);
        mon_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic send_word(input bit is_cfg, input logic [63:0] d, input bit last, output int hs_cyc);
    bit    ok = 1'b0;
    string tg;
    hs_cyc = 0;
    if (!is_cfg) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    if (is_cfg) begin
      tg = "cfg_hs";
      cfg_tdata = d; cfg_tvalid = 1'b1;
    end else begin
      tg = "spk_hs";
      spk_tdata = d; spk_tlast = last; spk_tvalid = 1'b1;
    end
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge clk);
      if (is_cfg ? cfg_tready : spk_tready) begin
        ok = 1'b1;
        hs_cyc = cyc;
        if (is_cfg) check("cfg_spk_tready", 64'(spk_tready), 64'd0);
      end
    end
    @(posedge clk); #1;
    cfg_tvalid = 1'b0; spk_tvalid = 1'b0; spk_tlast = 1'b0;
    check(tg, 64'(ok), 64'd1);
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int t = 0; t < 3000 && !seen; t++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
  endtask

  // One run: expected stream = per step, non-TIK spikes then TIK; abort truncates after that step
  task automatic do_run(input string tag, input int steps, input logic [31:0] tik, input int nw,
                        input bit inject, input bit allow_tik, input int abort_at);
    logic [63:0] exp_q[$];
    logic [63:0] w;
    logic [63:0] tik_w;
    int          hs;
    int          n;
    int          idle;
    int          exp_steps;
    bit          stop = 1'b0;
    tik_w = {5'b0, TIK_T, 24'b0, tik};
    exp_steps = steps;
    @(posedge clk); #1;
    mon_q.delete(); mon_cyc.delete(); done_cnt = 0;
    run_steps = STEP_W'(steps); tik_len = tik; run_start = 1'b1;
    @(posedge clk); #1;
    run_start = 1'b0;
    @(negedge clk);
    check({tag, "_running"}, 64'(running), 64'd1);
    @(posedge clk); #1;
    for (int s = 0; s < steps && !stop; s++) begin
      n = (nw > 0) ? nw : int'($urandom_range(1, 4));
      for (int k = 0; k < n; k++) begin
        w = {$urandom, $urandom};
        if (!allow_tik && w[58:56] == TIK_T) w[56] = 1'b0;
        if (inject && s == 0 && k == 1) w = 64'h0300_0000_0000_0010;
        if (w[58:56] == TIK_T) begin
          if (drop_exp < 255) drop_exp++;
        end else begin
          exp_q.push_back(w);
        end
        send_word(1'b0, w, k == n - 1, hs);
        if (abort_at == s) begin
          abort = 1'b1;
          stop = 1'b1;
          exp_steps = s + 1;
          break;
        end
      end
      exp_q.push_back(tik_w);
    end
    wait_done(tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    abort = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_running_end"}, 64'(running), 64'd0);
    check({tag, "_step_cnt"}, 64'(step_cnt), 64'(exp_steps));
    check({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(drop_exp));
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check({tag, "_nwords"}, 64'(mon_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), mon_q[i], exp_q[i]);
    for (int i = 0; i < mon_q.size(); i++) begin
      if (mon_q[i][58:56] == TIK_T) begin
        idle = (i + 1 < mon_q.size()) ? mon_cyc[i+1] - mon_cyc[i] - 1 : done_cyc - mon_cyc[i] - 1;
        check($sformatf("%s_gap%0d", tag, i), 64'(idle >= int'(tik) + int'(GAP_EXTRA)), 64'd1);
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_tvalid"}, 64'(out_tvalid), 64'd0);
    check({tag, "_out_tdata"}, out_tdata, 64'd0);
    check({tag, "_cfg_tready"}, 64'(cfg_tready), 64'd0);
    check({tag, "_spk_tready"}, 64'(spk_tready), 64'd0);
    check({tag, "_running"}, 64'(running), 64'd0);
    check({tag, "_step_cnt"}, 64'(step_cnt), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
  endtask

  initial begin
    logic [63:0] cw[3];
    int          hs_c[3];
    int          hs;
    rst_n = 1'b0; cfg_tdata = '0; cfg_tvalid = 1'b0;
    spk_tdata = '0; spk_tvalid = 1'b0; spk_tlast = 1'b0;
    run_start = 1'b0; run_steps = '0; tik_len = '0; abort = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Config passthrough in idle
    mon_q.delete(); mon_cyc.delete();
    for (int i = 0; i < 3; i++) begin
      cw[i] = {$urandom, $urandom};
      send_word(1'b1, cw[i], 1'b0, hs_c[i]);
    end
    repeat (3) @(negedge clk);
    check("cfg_nwords", 64'(mon_q.size()), 64'd3);
    for (int i = 0; i < 3 && i < mon_q.size(); i++) begin
      check($sformatf("cfg_w%0d", i), mon_q[i], cw[i]);
      check($sformatf("cfg_lat%0d", i), 64'(mon_cyc[i] - hs_c[i]), 64'd1);
    end

    // Two steps, three spikes each, explicit TIK encoding
    do_run("run2", 2, 32'd4, 3, 1'b0, 1'b0, -1);
    if (mon_q.size() > 3) check("run2_tik_word", mon_q[3], 64'h0300_0000_0000_0004);
    else check("run2_tik_present", 64'(mon_q.size()), 64'd8);

    bp_mode = 1;
    do_run("bp", 3, 32'd2, 4, 1'b0, 1'b0, -1);
    bp_mode = 0;

    do_run("filt", 2, 32'd1, 3, 1'b1, 1'b0, -1);
    check("filt_drop_one", 64'(drop_cnt), 64'd1);

    do_run("abort", 5, 32'd3, 3, 1'b0, 1'b0, 0);
    @(negedge clk);
    check("abort_cfg_tready", 64'(cfg_tready), 64'd1);

    bp_mode = 2;
    for (int r = 0; r < 4; r++)
      do_run($sformatf("rnd%0d", r), int'($urandom_range(1, 4)), 32'($urandom_range(0, 12)),
             0, 1'b0, 1'b1, -1);
    bp_mode = 0;

    // Zero-step run: done one cycle after run_start, nothing sent
    @(posedge clk); #1;
    mon_q.delete(); mon_cyc.delete(); done_cnt = 0;
    run_steps = '0; run_start = 1'b1;
    @(posedge clk); #1;
    run_start = 1'b0;
    @(negedge clk);
    check("zero_done", 64'(done), 64'd1);
    @(negedge clk);
    check("zero_done_clear", 64'(done), 64'd0);
    check("zero_running", 64'(running), 64'd0);
    check("zero_step_cnt", 64'(step_cnt), 64'd0);
    repeat (3) @(negedge clk);
    check("zero_nwords", 64'(mon_q.size()), 64'd0);
    check("zero_done_cnt", 64'(done_cnt), 64'd1);

    // Reset asserted while waiting out the tik window
    @(posedge clk); #1;
    run_steps = STEP_W'(3); tik_len = 32'd20; run_start = 1'b1;
    @(posedge clk); #1;
    run_start = 1'b0;
    send_word(1'b0, 64'h0000_1111_2222_3333, 1'b0, hs);
    send_word(1'b0, 64'h0000_4444_5555_6666, 1'b1, hs);
    repeat (6) @(posedge clk);
    #1;
    check("gap_running", 64'(running), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_values("midrst");
    drop_exp = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_cfg_tready", 64'(cfg_tready), 64'd1);
    check("midrst_running", 64'(running), 64'd0);

    do_run("post", 1, 32'd0, 1, 1'b0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
